// File: rtl/core_commit_unit_pkg.sv
// Types shared between the re-order buffer and the commit stage:
// the op encoding and the ROB entry layout.
package core_commit_unit_pkg;

    localparam int CCU_DATA_W = 32;
    localparam int CCU_ADDR_W = 32;
    localparam int CCU_REG_W  = 4;

    typedef enum logic [1:0] {
        OP_ALU = 2'd0,
        OP_LD  = 2'd1,
        OP_ST  = 2'd2,
        OP_BR  = 2'd3
    } op_t;

    typedef struct packed {
        logic                  dn;
        logic                  exc;
        logic                  wb;
        op_t                   op;
        logic [CCU_REG_W-1:0]  rd;
        logic [CCU_DATA_W-1:0] res;
        logic [CCU_ADDR_W-1:0] addr;
        logic [CCU_ADDR_W-1:0] pc;
    } rob_entry_t;

endpackage

// File: rtl/core_commit_unit.sv
// In-order retirement stage: commits the ROB tail to the register file,
// to memory via a store handshake, or raises a flush with a redirect PC.
module core_commit_unit
    import core_commit_unit_pkg::*;
#(
    parameter int ROB_LEN   = 16,
    parameter int DATA_W    = CCU_DATA_W,
    parameter int ADDR_W    = CCU_ADDR_W,
    parameter int REG_W     = CCU_REG_W,
    parameter int FLUSH_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  rob_entry_t                 rob_dat,
    input  logic [$clog2(ROB_LEN)-1:0] rob_occ,
    output logic                       rob_pop,
    output logic                       rf_we,
    output logic [REG_W-1:0]           rf_addr,
    output logic [DATA_W-1:0]          rf_dat,
    output logic                       st_req,
    output logic [ADDR_W-1:0]          st_addr,
    output logic [DATA_W-1:0]          st_dat,
    input  logic                       st_ack,
    output logic                       flush,
    output logic [ADDR_W-1:0]          redir_pc,
    output logic [31:0]                retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        STORE = 2'd2,
        FLUSH = 2'd3
    } commit_state_t;

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);

    commit_state_t     state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              rob_pop_d, rf_we_d, st_req_d, flush_d;
    logic [REG_W-1:0]  rf_addr_d;
    logic [DATA_W-1:0] rf_dat_d, st_dat_d;
    logic [ADDR_W-1:0] st_addr_d, redir_pc_d;
    logic [31:0]       retired_d;
    logic              eligible;

    assign eligible = (rob_occ != '0) && rob_dat.dn;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rob_pop_d  = 1'b0;
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr;
        rf_dat_d   = rf_dat;
        st_req_d   = st_req;
        st_addr_d  = st_addr;
        st_dat_d   = st_dat;
        flush_d    = flush;
        redir_pc_d = redir_pc;
        retired_d  = retired;
        unique case (state)
            IDLE: begin
                if (eligible) begin
                    if (rob_dat.exc) begin
                        flush_d    = 1'b1;
                        redir_pc_d = ADDR_W'(rob_dat.pc);
                        cnt_d      = CNT_INIT;
                        state_d    = FLUSH;
                    end else if (rob_dat.op == OP_ST) begin
                        st_req_d  = 1'b1;
                        st_addr_d = ADDR_W'(rob_dat.addr);
                        st_dat_d  = DATA_W'(rob_dat.res);
                        state_d   = STORE;
                    end else begin
                        rob_pop_d = 1'b1;
                        rf_we_d   = rob_dat.wb;
                        rf_addr_d = REG_W'(rob_dat.rd);
                        rf_dat_d  = DATA_W'(rob_dat.res);
                        retired_d = retired + 32'd1;
                        state_d   = POP;
                    end
                end
            end
            // Gap cycle: the ROB shows its new head only after the pop is sampled.
            POP: state_d = IDLE;
            STORE: begin
                if (st_ack) begin
                    st_req_d  = 1'b0;
                    rob_pop_d = 1'b1;
                    retired_d = retired + 32'd1;
                    state_d   = POP;
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    flush_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rob_pop  <= 1'b0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_dat   <= '0;
            st_req   <= 1'b0;
            st_addr  <= '0;
            st_dat   <= '0;
            flush    <= 1'b0;
            redir_pc <= '0;
            retired  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rob_pop  <= rob_pop_d;
            rf_we    <= rf_we_d;
            rf_addr  <= rf_addr_d;
            rf_dat   <= rf_dat_d;
            st_req   <= st_req_d;
            st_addr  <= st_addr_d;
            st_dat   <= st_dat_d;
            flush    <= flush_d;
            redir_pc <= redir_pc_d;
            retired  <= retired_d;
        end
    end

endmodule

// File: tb/tb_core_commit_unit.sv
// Bench for core_commit_unit: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level ROB model.
module tb_core_commit_unit;
    import core_commit_unit_pkg::*;

    localparam int FLUSH_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    rob_entry_t  rob_dat;
    logic [3:0]  rob_occ;
    logic        rob_pop, rf_we, st_req, st_ack, flush;
    logic [3:0]  rf_addr;
    logic [31:0] rf_dat, st_addr, st_dat, redir_pc, retired;

    int n_vec = 0;
    int n_bad = 0;

    core_commit_unit #(.FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst), .rob_dat(rob_dat), .rob_occ(rob_occ),
        .rob_pop(rob_pop), .rf_we(rf_we), .rf_addr(rf_addr), .rf_dat(rf_dat),
        .st_req(st_req), .st_addr(st_addr), .st_dat(st_dat), .st_ack(st_ack),
        .flush(flush), .redir_pc(redir_pc), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rob_entry_t mk(input logic dn, input logic exc, input logic wb, input op_t op,
                                      input logic [3:0] rd, input logic [31:0] res,
                                      input logic [31:0] addr, input logic [31:0] pc);
        rob_entry_t e;
        e.dn = dn; e.exc = exc; e.wb = wb; e.op = op; e.rd = rd;
        e.res = res; e.addr = addr; e.pc = pc;
        return e;
    endfunction

    task automatic quiet();
        rob_occ = '0;
        rob_dat = '0;
        st_ack  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string       name;
        rob_entry_t  e;
        logic [3:0]  occ;
        logic        x_pop, x_we, x_st, x_fl;
        logic [3:0]  x_addr;
        logic [31:0] x_dat, x_saddr, x_sdat, x_pc;
    } vec_t;

    // Transaction-level ROB model for the random phase
    typedef struct { rob_entry_t e; int dly; } slot_t;
    typedef struct { logic st; logic wb; logic [3:0] rd; logic [31:0] res; logic [31:0] addr; } cmt_t;

    task automatic random_phase(input int rounds);
        slot_t q[$];
        cmt_t  exp_q[$];
        cmt_t  c;
        rob_entry_t e;
        logic [31:0] exp_ret = 32'd0;
        logic [31:0] exp_pc;
        bit exp_fl, fl_prev, fl_seen, hs_done, done;
        int fl_len, k, exc_at;
        for (int r = 0; r < rounds; r++) begin
            k = int'($urandom_range(1, 6));
            exc_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, k - 1)) : -1;
            exp_fl = (exc_at >= 0);
            exp_pc = '0;
            for (int i = 0; i < k; i++) begin
                slot_t s;
                e = mk(1'b0, (i == exc_at), 1'($urandom), op_t'($urandom_range(0, 3)),
                       4'($urandom), $urandom, $urandom, $urandom);
                s.e = e;
                s.dly = int'($urandom_range(0, 3));
                q.push_back(s);
                if (i == exc_at) exp_pc = e.pc;
                if (exc_at < 0 || i < exc_at) begin
                    c.st = (e.op == OP_ST); c.wb = e.wb; c.rd = e.rd; c.res = e.res; c.addr = e.addr;
                    exp_q.push_back(c);
                    exp_ret++;
                end
            end
            fl_prev = 0; fl_seen = 0; fl_len = 0; hs_done = 0; done = 0;
            for (int cyc = 0; cyc < 300 && !done; cyc++) begin
                @(negedge clk);
                if (rob_pop) begin
                    if (q.size() > 0) void'(q.pop_front());
                    if (exp_q.size() == 0) begin
                        chk("rnd_unexpected_pop", 64'(rob_pop), 64'd0);
                    end else begin
                        c = exp_q.pop_front();
                        chk("rnd_pop_we", 64'(rf_we), 64'(c.st ? 1'b0 : c.wb));
                        if (c.st) begin
                            chk("rnd_store_handshake", 64'(hs_done), 64'd1);
                            hs_done = 0;
                        end else begin
                            chk("rnd_rf_addr", 64'(rf_addr), 64'(c.rd));
                            chk("rnd_rf_dat", 64'(rf_dat), 64'(c.res));
                        end
                    end
                end else if (rf_we) begin
                    chk("rnd_we_without_pop", 64'(rf_we), 64'd0);
                end
                if (flush) begin
                    if (!fl_prev) begin
                        chk("rnd_flush_expected", 64'(exp_fl), 64'd1);
                        chk("rnd_redir_pc", 64'(redir_pc), 64'(exp_pc));
                    end
                    if (rob_pop) chk("rnd_pop_in_flush", 64'(rob_pop), 64'd0);
                    fl_len++;
                    q.delete();
                end else if (fl_prev) begin
                    chk("rnd_flush_len", 64'(fl_len), 64'(FLUSH_CYC));
                    fl_seen = 1;
                end
                fl_prev = flush;
                st_ack = st_req ? ($urandom_range(0, 2) == 0) : 1'b0;
                if (st_req && st_ack) begin
                    if (exp_q.size() == 0 || !exp_q[0].st) begin
                        chk("rnd_unexpected_store", 64'(st_req), 64'd0);
                    end else begin
                        chk("rnd_st_addr", 64'(st_addr), 64'(exp_q[0].addr));
                        chk("rnd_st_dat", 64'(st_dat), 64'(exp_q[0].res));
                        hs_done = 1;
                    end
                end
                if (q.size() > 0) begin
                    rob_dat = q[0].e;
                    rob_dat.dn = (q[0].dly == 0);
                    if (q[0].dly > 0) q[0].dly--;
                    rob_occ = 4'(q.size());
                end else begin
                    rob_dat = '0;
                    rob_occ = '0;
                end
                done = (q.size() == 0) && !st_req && !flush && !rob_pop && !fl_prev;
            end
            if (!done) chk("rnd_timeout", 64'd0, 64'd1);
            chk("rnd_all_committed", 64'(exp_q.size()), 64'd0);
            chk("rnd_flush_seen", 64'(fl_seen), 64'(exp_fl));
            chk("rnd_retired", 64'(retired), 64'(exp_ret));
            exp_q.delete();
            q.delete();
            quiet();
        end
    endtask

    initial begin
        vec_t vt[8];
        logic [31:0] exp_ret;
        int pops, last_pop, cyc;
        logic [31:0] res_b2b[4];

        do_reset();
        chk("rst_rob_pop", 64'(rob_pop), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_rf_dat", 64'(rf_dat), 64'd0);
        chk("rst_st_req", 64'(st_req), 64'd0);
        chk("rst_st_addr", 64'(st_addr), 64'd0);
        chk("rst_st_dat", 64'(st_dat), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redir_pc", 64'(redir_pc), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);

        // ---- directed table: one entry presented in IDLE, outputs one cycle later
        vt[0] = '{"alu_wb", mk(1,0,1,OP_ALU,4'd5,32'hDEAD,32'h0,32'h0), 4'd1, 1,1,0,0, 4'd5, 32'hDEAD, 0, 0, 0};
        vt[1] = '{"ld_nowb", mk(1,0,0,OP_LD,4'd3,32'h1234,32'h0,32'h0), 4'd2, 1,0,0,0, 4'd3, 32'h1234, 0, 0, 0};
        vt[2] = '{"store", mk(1,0,0,OP_ST,4'd0,32'h55,32'h100,32'h0), 4'd1, 0,0,1,0, 4'd0, 32'h0, 32'h100, 32'h55, 0};
        vt[3] = '{"exc_br", mk(1,1,1,OP_BR,4'd2,32'h9,32'h0,32'h400), 4'd1, 0,0,0,1, 4'd0, 32'h0, 0, 0, 32'h400};
        vt[4] = '{"empty_rob", mk(1,0,1,OP_ALU,4'd7,32'h77,32'h0,32'h0), 4'd0, 0,0,0,0, 4'd0, 32'h0, 0, 0, 0};
        vt[5] = '{"not_done", mk(0,0,1,OP_ALU,4'd7,32'h77,32'h0,32'h0), 4'd3, 0,0,0,0, 4'd0, 32'h0, 0, 0, 0};
        vt[6] = '{"exc_over_st", mk(1,1,0,OP_ST,4'd1,32'h1,32'h200,32'h88), 4'd1, 0,0,0,1, 4'd0, 32'h0, 0, 0, 32'h88};
        vt[7] = '{"st_wb_set", mk(1,0,1,OP_ST,4'd9,32'hCAFE,32'hBEEF0,32'h0), 4'd1, 0,0,1,0, 4'd0, 32'h0, 32'hBEEF0, 32'hCAFE, 0};
        exp_ret = 32'd0;
        foreach (vt[i]) begin
            rob_dat = vt[i].e;
            rob_occ = vt[i].occ;
            @(negedge clk);
            quiet();
            chk({vt[i].name, "_pop"}, 64'(rob_pop), 64'(vt[i].x_pop));
            chk({vt[i].name, "_we"}, 64'(rf_we), 64'(vt[i].x_we));
            chk({vt[i].name, "_st_req"}, 64'(st_req), 64'(vt[i].x_st));
            chk({vt[i].name, "_flush"}, 64'(flush), 64'(vt[i].x_fl));
            if (vt[i].x_pop) begin
                chk({vt[i].name, "_rf_addr"}, 64'(rf_addr), 64'(vt[i].x_addr));
                chk({vt[i].name, "_rf_dat"}, 64'(rf_dat), 64'(vt[i].x_dat));
                exp_ret++;
            end
            if (vt[i].x_fl) chk({vt[i].name, "_redir"}, 64'(redir_pc), 64'(vt[i].x_pc));
            if (vt[i].x_st) begin
                chk({vt[i].name, "_st_addr"}, 64'(st_addr), 64'(vt[i].x_saddr));
                chk({vt[i].name, "_st_dat"}, 64'(st_dat), 64'(vt[i].x_sdat));
                st_ack = 1'b1;
                @(negedge clk);
                st_ack = 1'b0;
                chk({vt[i].name, "_ack_pop"}, 64'(rob_pop), 64'd1);
                chk({vt[i].name, "_ack_req"}, 64'(st_req), 64'd0);
                chk({vt[i].name, "_ack_we"}, 64'(rf_we), 64'd0);
                exp_ret++;
            end
            repeat (4) @(negedge clk);
            chk({vt[i].name, "_retired"}, 64'(retired), 64'(exp_ret));
        end

        // ---- head not done for 10 cycles, then a single commit
        rob_dat = mk(0,0,1,OP_ALU,4'd6,32'h66,32'h0,32'h0);
        rob_occ = 4'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rob_pop || rf_we) chk("stall_no_commit", {62'd0, rob_pop, rf_we}, 64'd0);
        end
        n_vec++;
        rob_dat.dn = 1'b1;
        @(negedge clk);
        quiet();
        chk("stall_commit_pop", 64'(rob_pop), 64'd1);
        chk("stall_commit_dat", 64'(rf_dat), 64'h66);
        @(negedge clk);
        chk("stall_single_pop", 64'(rob_pop), 64'd0);
        exp_ret++;

        // ---- store with ack held low for 4 cycles
        rob_dat = mk(1,0,1,OP_ST,4'd4,32'h55,32'h100,32'h0);
        rob_occ = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            quiet();
            if (!st_req || st_addr !== 32'h100 || st_dat !== 32'h55 || rf_we || rob_pop)
                chk("st_hold", {st_req, rf_we, rob_pop, st_addr[28:0], st_dat}, {3'b100, 29'h100, 32'h55});
            if (i == 4) st_ack = 1'b1;
        end
        n_vec++;
        @(negedge clk);
        st_ack = 1'b0;
        chk("st_pop_after_ack", 64'(rob_pop), 64'd1);
        chk("st_req_dropped", 64'(st_req), 64'd0);
        chk("st_no_we", 64'(rf_we), 64'd0);
        exp_ret++;
        @(negedge clk);
        chk("st_retired", 64'(retired), 64'(exp_ret));

        // ---- exception: flush exactly FLUSH_CYC cycles, no pop, retired unchanged
        rob_dat = mk(1,1,1,OP_ALU,4'd1,32'h1,32'h0,32'h400);
        rob_occ = 4'd1;
        @(negedge clk);
        quiet();
        for (int i = 0; i < FLUSH_CYC; i++) begin
            chk("exc_flush_hi", 64'(flush), 64'd1);
            chk("exc_redir", 64'(redir_pc), 64'h400);
            chk("exc_no_pop", 64'(rob_pop), 64'd0);
            @(negedge clk);
        end
        chk("exc_flush_lo", 64'(flush), 64'd0);
        chk("exc_retired", 64'(retired), 64'(exp_ret));

        // ---- back-to-back: four ALU entries, pops spaced 2 cycles apart
        foreach (res_b2b[i]) res_b2b[i] = 32'hA0 + 32'(i);
        pops = 0; last_pop = -10;
        rob_dat = mk(1,0,1,OP_ALU,4'd0,res_b2b[0],32'h0,32'h0);
        rob_occ = 4'd4;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (rob_pop) begin
                chk("b2b_dat", 64'(rf_dat), 64'(res_b2b[pops]));
                if (pops > 0) chk("b2b_spacing", 64'(cyc - last_pop), 64'd2);
                last_pop = cyc;
                pops++;
                if (pops < 4) begin
                    rob_dat = mk(1,0,1,OP_ALU,4'(pops),res_b2b[pops],32'h0,32'h0);
                    rob_occ = 4'(4 - pops);
                end else begin
                    quiet();
                end
            end
        end
        chk("b2b_pops", 64'(pops), 64'd4);
        chk("b2b_retired", 64'(retired), 64'(exp_ret + 32'd4));

        // ---- reset mid-STORE abandons the store and clears everything
        rob_dat = mk(1,0,0,OP_ST,4'd0,32'h77,32'h300,32'h0);
        rob_occ = 4'd1;
        repeat (2) @(negedge clk);
        quiet();
        chk("rstst_req_before", 64'(st_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstst_outputs", {rob_pop, rf_we, st_req, flush, rf_addr, 12'd0, retired},
            64'd0);
        chk("rstst_data", {st_addr, st_dat | rf_dat | redir_pc}, 64'd0);
        rob_dat = mk(1,0,1,OP_ALU,4'd2,32'h22,32'h0,32'h0);
        rob_occ = 4'd1;
        @(negedge clk);
        quiet();
        chk("rstst_idle_commit", 64'(rob_pop), 64'd1);
        repeat (2) @(negedge clk);

        // ---- retired wraps from 0xFFFFFFFF to 0
        force dut.retired = 32'hFFFF_FFFF;
        #1 release dut.retired;
        @(negedge clk);
        chk("wrap_preload", 64'(retired), 64'hFFFF_FFFF);
        rob_dat = mk(1,0,1,OP_ALU,4'd3,32'h33,32'h0,32'h0);
        rob_occ = 4'd1;
        @(negedge clk);
        quiet();
        chk("wrap_zero", 64'(retired), 64'd0);
        @(negedge clk);

        // ---- randomized traffic against the ROB model
        do_reset();
        random_phase(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
